// File: rtl/frame_buffer_sink.sv
// Triple-buffered frame store: a renderer fills one bank while the display scans another,
// and completed frames are handed over through a single "ready" bank.
module frame_buffer_sink #(
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 180,
   parameter int H_BITS         = 9,
   parameter int V_BITS         = 8,
   parameter int COLOR_BITS     = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [H_BITS-1:0]     pix_hcount_in,
   input  logic [V_BITS-1:0]     pix_vcount_in,
   input  logic [COLOR_BITS-1:0] pix_color_in,
   input  logic                  pix_valid_in,
   input  logic                  new_frame_in,
   input  logic [H_BITS-1:0]     disp_hcount_in,
   input  logic [V_BITS-1:0]     disp_vcount_in,
   input  logic                  disp_frame_start_in,
   output logic [COLOR_BITS-1:0] disp_color_out,
   output logic                  disp_valid_out,
   output logic                  frame_swap_out,
   output logic [15:0]           dropped_frames_out
);

   localparam int DEPTH     = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int ADDR_BITS = $clog2(3 * DEPTH);

   // Flat address of a pixel inside the three-bank store.
   function automatic logic [ADDR_BITS-1:0] bank_addr(input logic [1:0]        bank,
                                                      input logic [H_BITS-1:0] h,
                                                      input logic [V_BITS-1:0] v);
      return ADDR_BITS'(bank) * ADDR_BITS'(DEPTH)
           + ADDR_BITS'(v) * ADDR_BITS'(DISPLAY_WIDTH)
           + ADDR_BITS'(h);
   endfunction

   // The one bank index (0..2) that is neither a nor b.
   function automatic logic [1:0] third_bank(input logic [1:0] a, input logic [1:0] b);
      return 2'd3 - a - b;
   endfunction

   logic [COLOR_BITS-1:0] mem_r [0:3*DEPTH-1];

   logic [1:0]            disp_bank_r, wr_bank_r, rdy_bank_r;
   logic [1:0]            disp_bank_s, wr_bank_s, rdy_bank_s;
   logic                  rdy_valid_r, wr_dirty_r, rdy_valid_s, wr_dirty_s;
   logic [15:0]           drop_cnt_r, drop_cnt_s;
   logic                  swap_r, swap_s;

   logic                  pix_accept_s, disp_in_range_s, frame_done_s;
   logic                  wr_en_r;
   logic [ADDR_BITS-1:0]  wr_addr_r;
   logic [COLOR_BITS-1:0] wr_color_r;
   logic [ADDR_BITS-1:0]  rd_addr_r;
   logic                  rd_valid_r;
   logic [COLOR_BITS-1:0] color_r;
   logic                  valid_r;

   assign pix_accept_s    = pix_valid_in
                          && (pix_hcount_in < H_BITS'(DISPLAY_WIDTH))
                          && (pix_vcount_in < V_BITS'(DISPLAY_HEIGHT));
   assign disp_in_range_s = (disp_hcount_in < H_BITS'(DISPLAY_WIDTH))
                          && (disp_vcount_in < V_BITS'(DISPLAY_HEIGHT));
   // A pixel arriving with new_frame_in is part of the completed frame, so it counts as dirt.
   assign frame_done_s    = new_frame_in && (wr_dirty_r || pix_accept_s);

   // Bank rotation: completion (publish/supersede) is applied before the display handover.
   always_comb begin
      disp_bank_s = disp_bank_r;
      wr_bank_s   = wr_bank_r;
      rdy_bank_s  = rdy_bank_r;
      rdy_valid_s = rdy_valid_r;
      wr_dirty_s  = wr_dirty_r;
      drop_cnt_s  = drop_cnt_r;
      swap_s      = 1'b0;
      if (frame_done_s) begin
         rdy_bank_s = wr_bank_r;
         wr_dirty_s = 1'b0;
         if (rdy_valid_r) begin
            wr_bank_s = rdy_bank_r;
            if (drop_cnt_r != 16'hFFFF) begin
               drop_cnt_s = drop_cnt_r + 16'd1;
            end else begin
               drop_cnt_s = drop_cnt_r;
            end
         end else begin
            wr_bank_s = third_bank(disp_bank_r, wr_bank_r);
         end
         if (disp_frame_start_in) begin
            disp_bank_s = wr_bank_r;
            rdy_valid_s = 1'b0;
            swap_s      = 1'b1;
            if (rdy_valid_r) begin
               wr_bank_s = rdy_bank_r;
            end else begin
               wr_bank_s = disp_bank_r;
            end
         end else begin
            rdy_valid_s = 1'b1;
         end
      end else if (disp_frame_start_in && rdy_valid_r) begin
         disp_bank_s = rdy_bank_r;
         rdy_valid_s = 1'b0;
         swap_s      = 1'b1;
         wr_dirty_s  = wr_dirty_r || pix_accept_s;
      end else begin
         wr_dirty_s  = wr_dirty_r || pix_accept_s;
      end
   end

   // Bank bookkeeping registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         disp_bank_r <= 2'd0;
         wr_bank_r   <= 2'd1;
         rdy_bank_r  <= 2'd2;
         rdy_valid_r <= 1'b0;
         wr_dirty_r  <= 1'b0;
         drop_cnt_r  <= 16'd0;
         swap_r      <= 1'b0;
      end else begin
         disp_bank_r <= disp_bank_s;
         wr_bank_r   <= wr_bank_s;
         rdy_bank_r  <= rdy_bank_s;
         rdy_valid_r <= rdy_valid_s;
         wr_dirty_r  <= wr_dirty_s;
         drop_cnt_r  <= drop_cnt_s;
         swap_r      <= swap_s;
      end
   end

   // Write stage 1: latch address with the bank current at acceptance.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         wr_color_r <= '0;
      end else begin
         wr_en_r    <= pix_accept_s;
         wr_addr_r  <= pix_accept_s ? bank_addr(wr_bank_r, pix_hcount_in, pix_vcount_in) : '0;
         wr_color_r <= pix_color_in;
      end
   end

   // Write stage 2: RAM write; a reset on this edge kills the pending write.
   always_ff @(posedge clk_in) begin
      if (wr_en_r && rst_in) begin
         mem_r[wr_addr_r] <= wr_color_r;
      end
   end

   // Read stage 1: address from the bank displayed when the scan position arrives.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rd_addr_r  <= '0;
         rd_valid_r <= 1'b0;
      end else begin
         rd_addr_r  <= disp_in_range_s ? bank_addr(disp_bank_r, disp_hcount_in, disp_vcount_in) : '0;
         rd_valid_r <= disp_in_range_s;
      end
   end

   // Read stage 2: registered color, forced to zero outside the active area.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         color_r <= '0;
         valid_r <= 1'b0;
      end else if (rd_valid_r) begin
         color_r <= mem_r[rd_addr_r];
         valid_r <= 1'b1;
      end else begin
         color_r <= '0;
         valid_r <= 1'b0;
      end
   end

   assign disp_color_out     = color_r;
   assign disp_valid_out     = valid_r;
   assign frame_swap_out     = swap_r;
   assign dropped_frames_out = drop_cnt_r;

endmodule

// File: tb/tb_frame_buffer_sink.sv
// Directed bench for frame_buffer_sink: a per-cycle vector table with hand-computed
// outputs, followed by a hand-written mid-frame reset sequence.
module tb_frame_buffer_sink;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [8:0]  pix_hcount_in;
   logic [7:0]  pix_vcount_in;
   logic [3:0]  pix_color_in;
   logic        pix_valid_in;
   logic        new_frame_in;
   logic [8:0]  disp_hcount_in;
   logic [7:0]  disp_vcount_in;
   logic        disp_frame_start_in;
   logic [3:0]  disp_color_out;
   logic        disp_valid_out;
   logic        frame_swap_out;
   logic [15:0] dropped_frames_out;

   int errors = 0;
   int checks = 0;

   frame_buffer_sink dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .pix_hcount_in       (pix_hcount_in),
      .pix_vcount_in       (pix_vcount_in),
      .pix_color_in        (pix_color_in),
      .pix_valid_in        (pix_valid_in),
      .new_frame_in        (new_frame_in),
      .disp_hcount_in      (disp_hcount_in),
      .disp_vcount_in      (disp_vcount_in),
      .disp_frame_start_in (disp_frame_start_in),
      .disp_color_out      (disp_color_out),
      .disp_valid_out      (disp_valid_out),
      .frame_swap_out      (frame_swap_out),
      .dropped_frames_out  (dropped_frames_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        pv;
      logic [8:0]  ph;
      logic [7:0]  pvc;
      logic [3:0]  pc;
      logic        nf;
      logic        ds;
      logic [8:0]  dh;
      logic [7:0]  dv;
      logic        e_swap;
      logic [15:0] e_drop;
      logic [3:0]  e_col;
      logic        e_val;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int pv, input int ph, input int pvc, input int pc,
                      input int nf, input int ds, input int dh, input int dv,
                      input int es, input int ed, input int ec, input int ev);
      vec_t v;
      v.pv = 1'(pv);  v.ph = 9'(ph);  v.pvc = 8'(pvc); v.pc = 4'(pc);
      v.nf = 1'(nf);  v.ds = 1'(ds);  v.dh = 9'(dh);   v.dv = 8'(dv);
      v.e_swap = 1'(es); v.e_drop = 16'(ed); v.e_col = 4'(ec); v.e_val = 1'(ev);
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input int ph, input int pvc, input int pc,
                        input logic nf, input logic ds, input int dh, input int dv);
      pix_valid_in        = pv;
      pix_hcount_in       = 9'(ph);
      pix_vcount_in       = 8'(pvc);
      pix_color_in        = 4'(pc);
      new_frame_in        = nf;
      disp_frame_start_in = ds;
      disp_hcount_in      = 9'(dh);
      disp_vcount_in      = 8'(dv);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic es, input int ed, input int ec, input logic ev);
      check({tag, ".swap"},  {31'd0, frame_swap_out}, {31'd0, es});
      check({tag, ".drop"},  {16'd0, dropped_frames_out}, 32'(ed));
      check({tag, ".color"}, {28'd0, disp_color_out}, 32'(ec));
      check({tag, ".valid"}, {31'd0, disp_valid_out}, {31'd0, ev});
   endtask

   initial begin
      // pv  ph  pv  pc  nf ds  dh  dv | swap drop col val
      add(0,   0,  0,  0, 1, 0, 400, 0,  0, 0,  0, 0);  // 0 empty new_frame ignored
      add(0,   0,  0,  0, 0, 1, 400, 0,  0, 0,  0, 0);  // 1 nothing ready, no swap
      add(1,   5,  3, 10, 0, 0, 400, 0,  0, 0,  0, 0);  // 2 bank1 (5,3)=A
      add(1, 319,179,  7, 0, 0, 400, 0,  0, 0,  0, 0);  // 3 last pixel
      add(1,   0,  1,  3, 0, 0, 400, 0,  0, 0,  0, 0);  // 4 (0,1) is where (320,0) would alias
      add(1, 320,  0, 15, 0, 0, 400, 0,  0, 0,  0, 0);  // 5 out of range
      add(1,   0,180, 15, 0, 0, 400, 0,  0, 0,  0, 0);  // 6 out of range
      add(0,   0,  0,  0, 1, 0, 400, 0,  0, 0,  0, 0);  // 7 publish
      add(0,   0,  0,  0, 0, 1, 400, 0,  1, 0,  0, 0);  // 8 swap to bank1
      add(0,   0,  0,  0, 0, 0,   5, 3,  0, 0,  0, 0);  // 9
      add(0,   0,  0,  0, 0, 0, 319,179, 0, 0, 10, 1);  // 10
      add(0,   0,  0,  0, 0, 0,   0, 1,  0, 0,  7, 1);  // 11
      add(0,   0,  0,  0, 0, 0, 320, 0,  0, 0,  3, 1);  // 12
      add(0,   0,  0,  0, 0, 0,   0,180, 0, 0,  0, 0);  // 13
      add(0,   0,  0,  0, 0, 0, 400, 0,  0, 0,  0, 0);  // 14
      add(1,   5,  3, 11, 0, 0, 400, 0,  0, 0,  0, 0);  // 15 bank2
      add(0,   0,  0,  0, 1, 0, 400, 0,  0, 0,  0, 0);  // 16 publish bank2
      add(1,   5,  3, 12, 0, 0, 400, 0,  0, 0,  0, 0);  // 17 bank0
      add(0,   0,  0,  0, 1, 0, 400, 0,  0, 1,  0, 0);  // 18 supersede, one drop
      add(0,   0,  0,  0, 0, 0,   5, 3,  0, 1,  0, 0);  // 19 still bank1
      add(0,   0,  0,  0, 0, 1, 400, 0,  1, 1, 10, 1);  // 20 swap to bank0
      add(0,   0,  0,  0, 0, 0,   5, 3,  0, 1,  0, 0);  // 21
      add(0,   0,  0,  0, 0, 0, 400, 0,  0, 1, 12, 1);  // 22 second frame shown
      add(1,   5,  3, 13, 0, 0, 400, 0,  0, 1,  0, 0);  // 23 bank2
      add(0,   0,  0,  0, 1, 1, 400, 0,  1, 1,  0, 0);  // 24 simultaneous, nothing ready
      add(0,   0,  0,  0, 0, 0,   5, 3,  0, 1,  0, 0);  // 25
      add(0,   0,  0,  0, 0, 0, 400, 0,  0, 1, 13, 1);  // 26
      add(1,   5,  3, 14, 0, 0, 400, 0,  0, 1,  0, 0);  // 27 bank0
      add(0,   0,  0,  0, 1, 0, 400, 0,  0, 1,  0, 0);  // 28 publish bank0
      add(1,   5,  3,  6, 0, 0, 400, 0,  0, 1,  0, 0);  // 29 bank1
      add(0,   0,  0,  0, 1, 1, 400, 0,  1, 2,  0, 0);  // 30 simultaneous with drop
      add(0,   0,  0,  0, 0, 0,   5, 3,  0, 2,  0, 0);  // 31
      add(0,   0,  0,  0, 0, 0, 400, 0,  0, 2,  6, 1);  // 32
      add(1,   6,  3,  2, 0, 0, 400, 0,  0, 2,  0, 0);  // 33 bank0
      add(1,   6,  3,  9, 1, 0, 400, 0,  0, 2,  0, 0);  // 34 same address, with new_frame
      add(0,   0,  0,  0, 0, 1, 400, 0,  1, 2,  0, 0);  // 35 swap to bank0
      add(0,   0,  0,  0, 0, 0,   6, 3,  0, 2,  0, 0);  // 36
      add(0,   0,  0,  0, 0, 0, 400, 0,  0, 2,  9, 1);  // 37 last write wins

      rst_in = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 400, 0);
      tick();
      tick();
      check_outs("reset", 1'b0, 0, 0, 1'b0);
      rst_in = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].pv, int'(vq[i].ph), int'(vq[i].pvc), int'(vq[i].pc),
               vq[i].nf, vq[i].ds, int'(vq[i].dh), int'(vq[i].dv));
         tick();
         check_outs($sformatf("vec%0d", i), vq[i].e_swap, int'(vq[i].e_drop),
                    int'(vq[i].e_col), vq[i].e_val);
      end

      // Mid-frame reset: bank2 is the write bank here; (8,3)=1 lands, (8,3)=5 is cancelled.
      drive(1'b1, 8, 3, 1, 1'b0, 1'b0, 400, 0); tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 400, 0); tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 400, 0); tick();
      drive(1'b1, 8, 3, 5, 1'b0, 1'b0, 400, 0); tick();
      rst_in = 1'b0;
      drive(1'b1, 9, 3, 5, 1'b0, 1'b1, 5, 3); tick();
      check_outs("rst_mid", 1'b0, 0, 0, 1'b0);
      rst_in = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 400, 0); tick();
      check_outs("rst_after", 1'b0, 0, 0, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 400, 0); tick();
      check_outs("rst_nf_ignored", 1'b0, 0, 0, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 400, 0); tick();
      check_outs("rst_no_swap", 1'b0, 0, 0, 1'b0);
      drive(1'b1, 5, 3, 4, 1'b0, 1'b0, 400, 0); tick();   // bank1
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 400, 0); tick();   // publish, wr -> bank2
      drive(1'b1, 5, 3, 8, 1'b0, 1'b0, 400, 0); tick();   // bank2
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 400, 0); tick();   // supersede
      check_outs("rst_drop", 1'b0, 1, 0, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 400, 0); tick();
      check_outs("rst_swap", 1'b1, 1, 0, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 8, 3); tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 5, 3); tick();
      check_outs("rst_cancelled_wr", 1'b0, 1, 1, 1'b1);
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 400, 0); tick();
      check_outs("rst_new_frame", 1'b0, 1, 8, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
